seq_shifter: RTL



---
 rtl/seq_shifter.sv | 109 ++++++++++
 1 files changed

// File: rtl/seq_shifter.sv
// Multi-cycle 8-bit logical shifter: one bit position per clock, zero fill.
// Optional rotate mode (rot port) enabled by defining SEQ_SHIFTER_ROTATE_EN.
module seq_shifter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] in,
  input  logic [2:0] shamt,
  input  logic       dir,
`ifdef SEQ_SHIFTER_ROTATE_EN
  input  logic       rot,
`endif
  output logic [7:0] out,
  output logic       busy,
  output logic       done
);

  localparam int unsigned DW = 8;
  localparam int unsigned SW = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t        state;
  logic [DW-1:0] work;
  logic [SW-1:0] cnt;
  logic          dir_q;
  logic          fill_l_c;
  logic          fill_r_c;
  logic [DW-1:0] shifted_c;

`ifdef SEQ_SHIFTER_ROTATE_EN
  logic rot_q;

  // Rotate recirculates the bit leaving the register into the vacated end.
  assign fill_l_c = rot_q & work[DW-1];
  assign fill_r_c = rot_q & work[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_q <= 1'b0;
    end else if ((state == IDLE || state == DONE) && start) begin
      rot_q <= rot;
    end
  end
`else
  assign fill_l_c = 1'b0;
  assign fill_r_c = 1'b0;
`endif

  // One-position shift of the work register in the captured direction.
  assign shifted_c = dir_q ? {work[DW-2:0], fill_l_c} : {fill_r_c, work[DW-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      work  <= '0;
      cnt   <= '0;
      dir_q <= 1'b0;
      out   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            work  <= in;
            dir_q <= dir;
            if (shamt == SW'(0)) begin
              out   <= in;
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              cnt   <= shamt;
              state <= SHIFT;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        SHIFT: begin
          work <= shifted_c;
          cnt  <= cnt - SW'(1);
          // Last shift publishes the result and ends the operation.
          if (cnt == SW'(1)) begin
            out   <= shifted_c;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
